// File: rtl/dict_pkg.sv
// Shared types and helpers for the runtime-loadable compression dictionary.
package dict_pkg;

  typedef enum logic [1:0] {
    DICT_EMPTY = 2'd0,
    DICT_LOAD  = 2'd1,
    DICT_READY = 2'd2
  } dict_state_e;

  function automatic int dict_depth(input int key_width);
    return 1 << key_width;
  endfunction

endpackage

// File: rtl/dict_match_array.sv
// Combinational value->key search over the valid dictionary entries; lowest index wins.
module dict_match_array
  import dict_pkg::*;
#(
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 8
) (
  input  logic [dict_depth(KEY_WIDTH)*VAL_WIDTH-1:0] mem_flat,
  input  logic [KEY_WIDTH:0]                         entry_count,
  input  logic [VAL_WIDTH-1:0]                       lookup_val,
  output logic                                       hit,
  output logic [KEY_WIDTH-1:0]                       key
);

  localparam int DEPTH = dict_depth(KEY_WIDTH);

  logic [DEPTH-1:0] eq_vec;

  always_comb begin
    eq_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eq_vec[i] = ((KEY_WIDTH+1)'(i) < entry_count) &&
                  (mem_flat[i*VAL_WIDTH +: VAL_WIDTH] == lookup_val);
    end
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    key = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eq_vec[i]) begin
        hit = 1'b1;
        key = KEY_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/dict_cam_loader.sv
// Loadable dictionary with registered compress (value->key) and decompress (key->value) lookups.
module dict_cam_loader
  import dict_pkg::*;
#(
  parameter int KEY_WIDTH  = 4,
  parameter int VAL_WIDTH  = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [VAL_WIDTH-1:0]  load_val,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  dict_ready,
  output logic [KEY_WIDTH:0]    entry_count,
  input  logic                  cmp_req_valid,
  input  logic [VAL_WIDTH-1:0]  cmp_req_val,
  output logic                  cmp_rsp_valid,
  output logic [KEY_WIDTH-1:0]  cmp_rsp_key,
  output logic                  cmp_rsp_hit,
  input  logic                  dcmp_req_valid,
  input  logic [KEY_WIDTH-1:0]  dcmp_req_key,
  output logic                  dcmp_rsp_valid,
  output logic [VAL_WIDTH-1:0]  dcmp_rsp_val,
  output logic                  dcmp_rsp_hit,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);

  localparam int DEPTH = dict_depth(KEY_WIDTH);
  localparam logic [KEY_WIDTH:0] LAST_SLOT = (KEY_WIDTH+1)'(DEPTH - 1);

  dict_state_e state;

  logic [VAL_WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*VAL_WIDTH-1:0] mem_flat;
  logic                       load_acc;
  logic                       cmp_acc;
  logic                       dcmp_acc;
  logic                       match_hit;
  logic [KEY_WIDTH-1:0]       match_key;
  logic                       dcmp_in_range;

  // A restart outranks a concurrent beat, so that beat never reaches memory.
  assign load_acc      = load_valid && load_ready && !load_start;
  assign cmp_acc       = cmp_req_valid && dict_ready;
  assign dcmp_acc      = dcmp_req_valid && dict_ready;
  assign dcmp_in_range = {1'b0, dcmp_req_key} < entry_count;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*VAL_WIDTH +: VAL_WIDTH] = mem[g];
  end

  dict_match_array #(
    .KEY_WIDTH (KEY_WIDTH),
    .VAL_WIDTH (VAL_WIDTH)
  ) u_match (
    .mem_flat    (mem_flat),
    .entry_count (entry_count),
    .lookup_val  (cmp_req_val),
    .hit         (match_hit),
    .key         (match_key)
  );

  // Contents need no reset: entry_count gates every read.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem[entry_count[KEY_WIDTH-1:0]] <= load_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= DICT_EMPTY;
      entry_count    <= '0;
      load_ready     <= 1'b0;
      dict_ready     <= 1'b0;
      cmp_rsp_valid  <= 1'b0;
      cmp_rsp_key    <= '0;
      cmp_rsp_hit    <= 1'b0;
      dcmp_rsp_valid <= 1'b0;
      dcmp_rsp_val   <= '0;
      dcmp_rsp_hit   <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      // Requests are served against pre-clear contents even on a restart edge.
      cmp_rsp_valid  <= cmp_acc;
      dcmp_rsp_valid <= dcmp_acc;
      if (cmp_acc) begin
        cmp_rsp_key <= match_key;
        cmp_rsp_hit <= match_hit;
      end
      if (dcmp_acc) begin
        dcmp_rsp_hit <= dcmp_in_range;
        dcmp_rsp_val <= dcmp_in_range ? mem[dcmp_req_key] : '0;
      end

      if (load_start) begin
        state       <= DICT_LOAD;
        entry_count <= '0;
        load_ready  <= 1'b1;
        dict_ready  <= 1'b0;
        hit_count   <= '0;
        miss_count  <= '0;
      end else begin
        if (cmp_acc) begin
          if (match_hit) begin
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end
        end
        case (state)
          DICT_LOAD: begin
            if (load_acc) begin
              entry_count <= entry_count + 1'b1;
              if (load_last || entry_count == LAST_SLOT) begin
                state      <= DICT_READY;
                load_ready <= 1'b0;
                dict_ready <= 1'b1;
              end
            end
          end
          DICT_READY: begin
            load_ready <= 1'b0;
            dict_ready <= 1'b1;
          end
          default: begin
            load_ready <= 1'b0;
            dict_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dict_cam_loader.sv
// Directed bench for dict_cam_loader built with 4-bit statistics counters.
module tb_dict_cam_loader;

  localparam int KW = 4;
  localparam int VW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, load_valid, load_last;
  logic [VW-1:0] load_val;
  logic          load_ready, dict_ready;
  logic [KW:0]   entry_count;
  logic          cmp_req_valid;
  logic [VW-1:0] cmp_req_val;
  logic          cmp_rsp_valid, cmp_rsp_hit;
  logic [KW-1:0] cmp_rsp_key;
  logic          dcmp_req_valid;
  logic [KW-1:0] dcmp_req_key;
  logic          dcmp_rsp_valid, dcmp_rsp_hit;
  logic [VW-1:0] dcmp_rsp_val;
  logic [SW-1:0] hit_count, miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dict_cam_loader #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .STAT_WIDTH(SW)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .load_valid     (load_valid),
    .load_val       (load_val),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .dict_ready     (dict_ready),
    .entry_count    (entry_count),
    .cmp_req_valid  (cmp_req_valid),
    .cmp_req_val    (cmp_req_val),
    .cmp_rsp_valid  (cmp_rsp_valid),
    .cmp_rsp_key    (cmp_rsp_key),
    .cmp_rsp_hit    (cmp_rsp_hit),
    .dcmp_req_valid (dcmp_req_valid),
    .dcmp_req_key   (dcmp_req_key),
    .dcmp_rsp_valid (dcmp_rsp_valid),
    .dcmp_rsp_val   (dcmp_rsp_val),
    .dcmp_rsp_hit   (dcmp_rsp_hit),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_val = '0;
    cmp_req_valid = 0; cmp_req_val = '0; dcmp_req_valid = 0; dcmp_req_key = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(entry_count), 0);
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_dict_ready", 32'(dict_ready), 0);
    chk("rst_cmp_valid", 32'(cmp_rsp_valid), 0);
    chk("rst_hits", 32'(hit_count), 0);

    // 3-beat load
    load_start = 1; step(); load_start = 0;
    chk("load_ready_on", 32'(load_ready), 1);
    chk("dict_ready_off", 32'(dict_ready), 0);
    load_valid = 1; load_val = 8'h11; step();
    load_val = 8'h22; step();
    load_val = 8'h33; load_last = 1; step();
    load_valid = 0; load_last = 0;
    chk("cnt3", 32'(entry_count), 3);
    chk("ready3", 32'(dict_ready), 1);
    chk("ldrdy3_off", 32'(load_ready), 0);

    cmp_req_valid = 1; cmp_req_val = 8'h22; step(); cmp_req_valid = 0;
    chk("cmp22_valid", 32'(cmp_rsp_valid), 1);
    chk("cmp22_key", 32'(cmp_rsp_key), 1);
    chk("cmp22_hit", 32'(cmp_rsp_hit), 1);
    chk("cmp22_hits", 32'(hit_count), 1);
    step();
    chk("cmp_idle_valid", 32'(cmp_rsp_valid), 0);
    chk("cmp_hold_key", 32'(cmp_rsp_key), 1);

    // stale value miss + out-of-range decompress together
    cmp_req_valid = 1; cmp_req_val = 8'h00; dcmp_req_valid = 1; dcmp_req_key = 4'd5;
    step(); cmp_req_valid = 0; dcmp_req_valid = 0;
    chk("miss_hit", 32'(cmp_rsp_hit), 0);
    chk("miss_key", 32'(cmp_rsp_key), 0);
    chk("miss_cnt", 32'(miss_count), 1);
    chk("dk5_valid", 32'(dcmp_rsp_valid), 1);
    chk("dk5_hit", 32'(dcmp_rsp_hit), 0);
    chk("dk5_val", 32'(dcmp_rsp_val), 0);
    dcmp_req_valid = 1; dcmp_req_key = 4'd2; step(); dcmp_req_valid = 0;
    chk("dk2_hit", 32'(dcmp_rsp_hit), 1);
    chk("dk2_val", 32'(dcmp_rsp_val), 32'h33);

    // full-depth load, no load_last
    load_start = 1; step(); load_start = 0;
    chk("clr_hits", 32'(hit_count), 0);
    chk("clr_miss", 32'(miss_count), 0);
    chk("clr_cnt", 32'(entry_count), 0);
    load_valid = 1;
    for (int i = 0; i < 16; i++) begin
      load_val = 8'h40 + 8'(i);
      step();
    end
    chk("full_cnt", 32'(entry_count), 16);
    chk("full_ready", 32'(dict_ready), 1);
    chk("full_ldrdy", 32'(load_ready), 0);
    load_val = 8'hEE; step(); load_valid = 0;
    chk("beat17_cnt", 32'(entry_count), 16);
    dcmp_req_valid = 1; dcmp_req_key = 4'd15; cmp_req_valid = 1; cmp_req_val = 8'hEE;
    step(); dcmp_req_valid = 0; cmp_req_valid = 0;
    chk("dk15_val", 32'(dcmp_rsp_val), 32'h4F);
    chk("dk15_hit", 32'(dcmp_rsp_hit), 1);
    chk("beat17_miss", 32'(cmp_rsp_hit), 0);

    // duplicates at 2 and 7
    load_start = 1; step(); load_start = 0;
    load_valid = 1;
    for (int i = 0; i < 8; i++) begin
      load_val  = (i == 2 || i == 7) ? 8'hAA : 8'(i);
      load_last = (i == 7);
      step();
    end
    load_valid = 0; load_last = 0;
    chk("dup_cnt", 32'(entry_count), 8);
    cmp_req_valid = 1; cmp_req_val = 8'hAA; dcmp_req_valid = 1; dcmp_req_key = 4'd7;
    step(); cmp_req_valid = 0; dcmp_req_valid = 0;
    chk("dup_key", 32'(cmp_rsp_key), 2);
    chk("dup_hit", 32'(cmp_rsp_hit), 1);
    chk("dup_dval", 32'(dcmp_rsp_val), 32'hAA);
    chk("dup_dvalid", 32'(dcmp_rsp_valid), 1);
    chk("dup_hits", 32'(hit_count), 1);

    // restart mid-load, request during LOAD is dropped
    load_start = 1; step(); load_start = 0;
    load_valid = 1;
    for (int i = 0; i < 5; i++) begin
      load_val = 8'h60 + 8'(i);
      cmp_req_valid = (i == 3);
      cmp_req_val = 8'h60;
      step();
    end
    cmp_req_valid = 0;
    chk("mid_cnt5", 32'(entry_count), 5);
    chk("load_cmp_drop", 32'(cmp_rsp_valid), 0);
    load_start = 1; load_val = 8'h99; step(); load_start = 0;
    chk("restart_cnt", 32'(entry_count), 0);
    chk("restart_ldrdy", 32'(load_ready), 1);
    load_val = 8'h01; step();
    load_val = 8'h02; load_last = 1; step();
    load_valid = 0; load_last = 0;
    chk("reload_cnt", 32'(entry_count), 2);
    chk("reload_ready", 32'(dict_ready), 1);
    dcmp_req_valid = 1; dcmp_req_key = 4'd0; step(); dcmp_req_valid = 0;
    chk("reload_dk0", 32'(dcmp_rsp_val), 32'h01);

    // saturation at 15 with 20 hits
    cmp_req_valid = 1; cmp_req_val = 8'h01;
    for (int i = 0; i < 20; i++) step();
    cmp_req_valid = 0;
    chk("sat_hits", 32'(hit_count), 15);
    chk("sat_miss", 32'(miss_count), 0);

    // request on the restart edge: served, statistic cleared
    cmp_req_valid = 1; cmp_req_val = 8'h02; load_start = 1; step();
    cmp_req_valid = 0; load_start = 0;
    chk("edge_valid", 32'(cmp_rsp_valid), 1);
    chk("edge_key", 32'(cmp_rsp_key), 1);
    chk("edge_hits", 32'(hit_count), 0);
    load_valid = 1; load_val = 8'h55; step(); load_valid = 0;
    chk("pre_rst_cnt", 32'(entry_count), 1);

    // async reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt", 32'(entry_count), 0);
    chk("arst_ldrdy", 32'(load_ready), 0);
    chk("arst_key", 32'(cmp_rsp_key), 0);
    chk("arst_hit", 32'(cmp_rsp_hit), 0);
    step();
    reset = 1'b0;
    load_valid = 1; load_val = 8'h77; step(); load_valid = 0;
    chk("empty_ignores_beat", 32'(entry_count), 0);
    chk("empty_dict_ready", 32'(dict_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dict_cam_loader.md
Name: dict_cam_loader

Overview:
- Runtime-loadable compression dictionary with bidirectional lookup.
- Compress path: value -> key. Decompress path: key -> value.
- Tracks how many entries are valid, so unloaded slots never match. Both paths are registered with a valid-qualified response.
- Sits between the instruction fetch/decompress stages and the boot-time dictionary loader; also keeps per-load hit/miss statistics.

Parameters:
- KEY_WIDTH, 4, compressed index width; depth = 2**KEY_WIDTH entries.
- VAL_WIDTH, 8, uncompressed field width.
- STAT_WIDTH, 16, width of the saturating hit/miss counters.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  pulse: discard contents, begin a new load.
- load_valid  in  1  load_val present this cycle.
- load_val  in  VAL_WIDTH  entry to append.
- load_last  in  1  qualifies load_valid: final entry.
- load_ready  out  1  load beat accepted when load_valid and load_ready.
- dict_ready  out  1  dictionary loaded, lookups enabled.
- entry_count  out  KEY_WIDTH+1  number of valid entries (0..2**KEY_WIDTH).
- cmp_req_valid  in  1  compress request.
- cmp_req_val  in  VAL_WIDTH  value to look up.
- cmp_rsp_valid  out  1  compress response valid.
- cmp_rsp_key  out  KEY_WIDTH  matching index (0 on miss).
- cmp_rsp_hit  out  1  value present.
- dcmp_req_valid  in  1  decompress request.
- dcmp_req_key  in  KEY_WIDTH  index to read.
- dcmp_rsp_valid  out  1  decompress response valid.
- dcmp_rsp_val  out  VAL_WIDTH  stored value (0 if key invalid).
- dcmp_rsp_hit  out  1  key < entry_count.
- hit_count  out  STAT_WIDTH  compress hits since last load_start.
- miss_count  out  STAT_WIDTH  compress misses since last load_start.

Behaviour:
- Reset (async, active-high):
  - State EMPTY; entry_count 0; load_ready 0; dict_ready 0.
  - All rsp outputs 0; counters 0.
  - Memory contents are don't-care; they are gated by entry_count.
- FSM states: EMPTY, LOAD, READY.
  - EMPTY: load_start -> LOAD.
  - LOAD:
    - load_ready=1.
    - Each accepted beat writes memory[entry_count] and increments entry_count.
    - Beat with load_last -> READY after that write.
    - The write that makes entry_count = 2**KEY_WIDTH -> READY; load_ready is 0 from the next cycle.
  - READY: dict_ready=1; load_ready=0; load_valid is ignored.
  - load_start in any state, same edge: entry_count <= 0, counters <= 0, -> LOAD. This includes restarting mid-LOAD.
  - load_start outranks a simultaneous load_valid: that beat is dropped.
  - load_last with zero prior entries plus one beat gives entry_count 1, READY.
- Lookups:
  - A request is accepted only when dict_ready=1 in that cycle. Otherwise it is dropped and the rsp_valid is 0 next cycle.
  - Latency is 1 cycle. rsp_valid(t+1) = req_valid(t) & dict_ready(t). Responses are fully registered, with no backpressure.
  - Compress match considers only indices < entry_count. With duplicates, the lowest index wins.
  - Decompress: dcmp_rsp_hit = (key < entry_count). dcmp_rsp_val = memory[key] on hit, else 0.
  - Response fields hold their last values when rsp_valid=0.
  - Both paths may issue in the same cycle and are independent.
  - load_start in the same cycle as an accepted request: the request is served against the pre-clear contents. Its statistic increment is lost, because the clear wins.
- Statistics:
  - Each accepted compress request increments hit_count or miss_count.
  - Counters saturate at all-ones (no wrap).
  - Decompress requests are not counted.
- Width: entry_count carries one extra bit so it can represent full depth; comparisons use zero-extended keys.

Decomposition:
- Package dict_pkg:
  - state enum DICT_EMPTY/DICT_LOAD/DICT_READY.
  - DEPTH derivation helper.
- Sub-module dict_match_array (combinational):
  - Inputs: flattened memory, entry_count, lookup value.
  - Outputs: hit, lowest-index key.
  - Implemented as a priority encoder over the per-entry compare vector.
- Top level holds the FSM, memory write port, response registers and counters.

Test Plan:
- Reset, then load 3 beats (0x11, 0x22, 0x33 with load_last) -> entry_count=3, dict_ready=1 the cycle after the last beat. Compress 0x22 -> next cycle cmp_rsp_valid=1, key=1, hit=1.
- With 3 entries loaded, compress 0x00 (a stale/unloaded slot value) -> hit=0, key=0, miss_count=1. Decompress key 5 -> dcmp_rsp_hit=0, val=0.
- Load 16 beats with no load_last (KEY_WIDTH=4) -> READY after the 16th beat, entry_count=16, load_ready=0. A 17th beat is ignored. Decompress key 15 returns the 16th value.
- Load duplicates 0xAA at index 2 and 7 -> compress 0xAA returns key=2. Issue a simultaneous decompress key 7 -> val=0xAA the same cycle.
- Issue load_start mid-LOAD after 5 beats -> entry_count=0, counters=0, reload works. Issue a compress request during LOAD -> no cmp_rsp_valid.
- Force 2**STAT_WIDTH-1 hits (small STAT_WIDTH=4 build, 20 hits) -> hit_count holds 15. Assert async reset mid-load -> all outputs 0 immediately, state EMPTY.
